// File: rtl/calcunit_seq_pkg.sv
// Shared types and constants for the eye-distance accumulator sequencer.
package calcunit_seq_pkg;

  localparam int unsigned NUM_SEG   = 4;
  localparam int unsigned SEG_CNT_W = 2;
  localparam int unsigned G2SUM_W   = 14;
  localparam int unsigned GSUM_W    = 11;
  localparam int unsigned FG_W      = 14;
  localparam int unsigned PLACE_W   = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_CLR_GAP,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_CL_SETUP,
    ST_CL_STROBE,
    ST_FIN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUT,
    ST_ADV
  } state_t;

endpackage

// File: rtl/calcunit_seq_addr.sv
// Sample/segment counters and frame-buffer address generation (wraps modulo 2^ADDR_W).
module calcunit_seq_addr
  import calcunit_seq_pkg::*;
#(
  parameter int unsigned SEG_LEN    = 16,
  parameter int unsigned SEG_STRIDE = 16,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic              first,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [7:0]           idx;
  logic [SEG_CNT_W-1:0] seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      seg <= '0;
    end else if (clear) begin
      idx <= '0;
      seg <= '0;
    end else if (step) begin
      if (idx == 8'(SEG_LEN - 1)) begin
        idx <= '0;
        seg <= seg + 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    first = (idx == '0);
    last  = (idx == 8'(SEG_LEN - 1)) && (seg == SEG_CNT_W'(NUM_SEG - 1));
    addr  = ADDR_W'(32'(base) + 32'(seg) * SEG_STRIDE + 32'(idx));
  end

endmodule

// File: rtl/calcunit_seq.sv
// Sequencer: clears the accumulator, streams 4 segments of samples, closes it,
// then hands the 4 segment results out over a valid/ready handshake.
module calcunit_seq
  import calcunit_seq_pkg::*;
#(
  parameter int unsigned SEG_LEN    = 16,
  parameter int unsigned SEG_STRIDE = 16,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [7:0]         base_place,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               cu_startsig,
  output logic               cu_work,
  output logic               cu_change,
  output logic               cu_finalstart,
  output logic               cu_valid,
  output logic [7:0]         cu_startplace,
  input  logic [G2SUM_W-1:0] cu_g2sum,
  input  logic [GSUM_W-1:0]  cu_gsum,
  input  logic [FG_W-1:0]    cu_fg,
  input  logic [PLACE_W-1:0] cu_place,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [G2SUM_W-1:0] res_g2sum,
  output logic [GSUM_W-1:0]  res_gsum,
  output logic [FG_W-1:0]    res_fg,
  output logic [PLACE_W-1:0] res_place,
  output logic [1:0]         res_idx
);

  state_t               state, state_next;
  logic [ADDR_W-1:0]    base_q;
  logic [SEG_CNT_W-1:0] k;
  logic                 last_q;
  logic                 first, last;
  logic [ADDR_W-1:0]    addr;

  // Counters advance as FETCH ends; last_q remembers whether that sample closes the stream.
  calcunit_seq_addr #(
    .SEG_LEN   (SEG_LEN),
    .SEG_STRIDE(SEG_STRIDE),
    .ADDR_W    (ADDR_W)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_IDLE),
    .step (state == ST_FETCH),
    .base (base_q),
    .first(first),
    .last (last),
    .addr (addr)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (start) state_next = ST_CLR;
      ST_CLR:       state_next = ST_CLR_GAP;
      ST_CLR_GAP:   state_next = ST_FETCH;
      ST_FETCH:     state_next = ST_SETUP;
      ST_SETUP:     state_next = ST_STROBE;
      ST_STROBE:    state_next = last_q ? ST_CL_SETUP : ST_FETCH;
      ST_CL_SETUP:  state_next = ST_CL_STROBE;
      ST_CL_STROBE: state_next = ST_FIN;
      ST_FIN:       state_next = ST_SETTLE;
      ST_SETTLE:    state_next = ST_CAPTURE;
      ST_CAPTURE:   state_next = ST_OUT;
      ST_OUT:       if (res_ready) state_next = ST_ADV;
      ST_ADV:       state_next = (k == SEG_CNT_W'(NUM_SEG - 1)) ? ST_IDLE : ST_CAPTURE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they line up with it registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      k             <= '0;
      last_q        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      cu_startsig   <= 1'b0;
      cu_work       <= 1'b0;
      cu_change     <= 1'b0;
      cu_finalstart <= 1'b0;
      cu_valid      <= 1'b0;
      cu_startplace <= '0;
      res_valid     <= 1'b0;
      res_g2sum     <= '0;
      res_gsum      <= '0;
      res_fg        <= '0;
      res_place     <= '0;
      res_idx       <= '0;
    end else begin
      state         <= state_next;
      busy          <= (state_next != ST_IDLE);
      rd_en         <= (state_next == ST_FETCH);
      cu_startsig   <= (state_next == ST_CLR);
      cu_work       <= (state_next == ST_STROBE) || (state_next == ST_CL_STROBE);
      cu_finalstart <= (state_next == ST_FIN);
      cu_valid      <= (state_next == ST_ADV) && (k != SEG_CNT_W'(NUM_SEG - 1));
      done          <= (state_next == ST_ADV) && (k == SEG_CNT_W'(NUM_SEG - 1));
      res_valid     <= (state_next == ST_OUT);

      if (state_next == ST_FETCH) rd_addr <= addr;

      unique case (state_next)
        ST_SETUP:                  cu_change <= first;
        ST_CL_SETUP:               cu_change <= 1'b1;
        ST_STROBE, ST_CL_STROBE:   cu_change <= cu_change;
        default:                   cu_change <= 1'b0;
      endcase

      if (state == ST_IDLE && start) begin
        base_q        <= base_addr;
        cu_startplace <= base_place;
      end
      if (state == ST_FETCH) last_q <= last;
      if (state == ST_IDLE)     k <= '0;
      else if (state == ST_ADV) k <= k + 1'b1;

      if (state == ST_CAPTURE) begin
        res_g2sum <= cu_g2sum;
        res_gsum  <= cu_gsum;
        res_fg    <= cu_fg;
        res_place <= cu_place;
        res_idx   <= k;
      end
    end
  end

endmodule

// File: tb/tb_calcunit_seq.sv
// Directed bench for calcunit_seq with a behavioural accumulator and frame-buffer model.
module tb_calcunit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  base_place;
  logic        busy, done, rd_en;
  logic [7:0]  rd_addr;
  logic        cu_startsig, cu_work, cu_change, cu_finalstart, cu_valid;
  logic [7:0]  cu_startplace;
  logic [13:0] cu_g2sum;
  logic [10:0] cu_gsum;
  logic [13:0] cu_fg;
  logic [5:0]  cu_place;
  logic        res_valid, res_ready;
  logic [13:0] res_g2sum;
  logic [10:0] res_gsum;
  logic [13:0] res_fg;
  logic [5:0]  res_place;
  logic [1:0]  res_idx;

  int n_tests = 0;
  int n_fail  = 0;

  calcunit_seq #(
    .SEG_LEN   (16),
    .SEG_STRIDE(16),
    .ADDR_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .base_place   (base_place),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .cu_startsig  (cu_startsig),
    .cu_work      (cu_work),
    .cu_change    (cu_change),
    .cu_finalstart(cu_finalstart),
    .cu_valid     (cu_valid),
    .cu_startplace(cu_startplace),
    .cu_g2sum     (cu_g2sum),
    .cu_gsum      (cu_gsum),
    .cu_fg        (cu_fg),
    .cu_place     (cu_place),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_g2sum    (res_g2sum),
    .res_gsum     (res_gsum),
    .res_fg       (res_fg),
    .res_place    (res_place),
    .res_idx      (res_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor, frame-buffer and accumulator model; all sampled on the falling edge.
  int ss_total = 0, work_total = 0, rd_total = 0, done_total = 0, valid_total = 0;
  int onehot_viol = 0, chg_viol = 0;
  logic [7:0] addr_log [1024];
  logic       chg_log  [1024];
  logic       prev_ss = 0, prev_wk = 0, prev_fs = 0, prev_cv = 0, prev_chg = 0;
  logic [10:0] mem_g  = '0;
  logic [13:0] mem_g2 = '0;
  logic [13:0] mem_fg = '0;
  logic [10:0] acc_g  [4];
  logic [13:0] acc_g2 [4];
  logic [13:0] acc_fg [4];
  int          ptr  = -1;
  int          optr = 4;
  logic [7:0]  fin_place = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(cu_startsig) + int'(cu_work) + int'(cu_finalstart) + int'(cu_valid) > 1)
        onehot_viol++;
      if ((cu_startsig && prev_ss) || (cu_work && prev_wk) ||
          (cu_finalstart && prev_fs) || (cu_valid && prev_cv))
        onehot_viol++;
      if (cu_work && (cu_change != prev_chg)) chg_viol++;
      if (cu_startsig) begin
        ss_total++;
        ptr = -1;
        for (int i = 0; i < 4; i++) begin
          acc_g[i] = '0; acc_g2[i] = '0; acc_fg[i] = '0;
        end
      end
      if (cu_work) begin
        chg_log[work_total % 1024] = cu_change;
        work_total++;
        if (cu_change) ptr++;
        if (ptr >= 0 && ptr < 4) begin
          acc_g[ptr[1:0]]  = acc_g[ptr[1:0]]  + mem_g;
          acc_g2[ptr[1:0]] = acc_g2[ptr[1:0]] + mem_g2;
          acc_fg[ptr[1:0]] = acc_fg[ptr[1:0]] + mem_fg;
        end
      end
      if (cu_finalstart) begin
        optr = 0;
        fin_place = cu_startplace;
      end
      if (cu_valid) begin
        optr++;
        valid_total++;
      end
      if (rd_en) begin
        addr_log[rd_total % 1024] = rd_addr;
        rd_total++;
        mem_g = 11'd1; mem_g2 = 14'd1; mem_fg = 14'd2;
      end
      if (done) done_total++;
      prev_ss = cu_startsig; prev_wk = cu_work; prev_fs = cu_finalstart;
      prev_cv = cu_valid;    prev_chg = cu_change;
    end
  end

  always_comb begin
    cu_gsum  = '0;
    cu_g2sum = '0;
    cu_fg    = '0;
    cu_place = '0;
    if (optr >= 0 && optr < 4) begin
      cu_gsum  = acc_g[optr[1:0]];
      cu_g2sum = acc_g2[optr[1:0]];
      cu_fg    = acc_fg[optr[1:0]];
      cu_place = 6'(fin_place + 8'(optr * 16));
    end
  end

  task automatic run(input logic [7:0] ba, input logic [7:0] bp, input int stall_k,
                     input bit ready_high, input bit inject, input bit abort);
    int rd0 = rd_total, wk0 = work_total, ss0 = ss_total, dn0 = done_total;
    int vl0 = valid_total, oh0 = onehot_viol, cv0 = chg_viol;
    int lat, w, bad;
    logic [13:0] s_g2, s_fg;
    logic [10:0] s_g;
    logic [5:0]  s_pl;
    logic [1:0]  s_ix;
    logic [7:0]  exp_a;

    @(negedge clk);
    base_addr = ba; base_place = bp; start = 1'b1; res_ready = ready_high;
    @(negedge clk);
    start = 1'b0; base_addr = ~ba; base_place = ~bp;
    lat = 0;
    while (!res_valid && lat < 400) begin
      if (inject && lat == 60) begin
        start = 1'b1; base_addr = 8'h77; base_place = 8'h3C;
      end else start = 1'b0;
      if (abort && lat == 120) begin
        #2 rst = 1'b1;
        #1 check("rst_outs_zero", 32'(|{busy, done, rd_en, rd_addr, cu_startsig, cu_work,
                 cu_change, cu_finalstart, cu_valid, cu_startplace, res_valid, res_g2sum,
                 res_gsum, res_fg, res_place, res_idx}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_busy", 32'(busy), 32'd0);
        return;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'd199);

    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!res_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_idx", 32'(res_idx), 32'(k));
      check("res_gsum", 32'(res_gsum), 32'd16);
      check("res_g2sum", 32'(res_g2sum), 32'd16);
      check("res_fg", 32'(res_fg), 32'd32);
      check("res_place", 32'(res_place), 32'(6'(bp + 8'(16 * k))));
      if (stall_k == k) begin
        s_g = res_gsum; s_g2 = res_g2sum; s_fg = res_fg; s_pl = res_place; s_ix = res_idx;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || cu_valid || res_gsum != s_g || res_g2sum != s_g2 ||
              res_fg != s_fg || res_place != s_pl || res_idx != s_ix)
            bad++;
        end
        check("stall_hold", 32'(bad), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = ready_high;
      check("valid_drop", 32'(res_valid), 32'd0);
      check("adv_cu_valid", 32'(cu_valid), 32'(k < 3));
      check("adv_done", 32'(done), 32'(k == 3));
    end

    repeat (3) @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("done_count", 32'(done_total - dn0), 32'd1);
    check("startsig_count", 32'(ss_total - ss0), 32'd1);
    check("work_count", 32'(work_total - wk0), 32'd65);
    check("rd_count", 32'(rd_total - rd0), 32'd64);
    check("cu_valid_count", 32'(valid_total - vl0), 32'd3);
    check("strobe_onehot", 32'(onehot_viol - oh0), 32'd0);
    check("change_stable", 32'(chg_viol - cv0), 32'd0);

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      exp_a = 8'(32'(ba) + 32'(i / 16) * 16 + 32'(i % 16));
      if (addr_log[(rd0 + i) % 1024] !== exp_a) bad++;
    end
    check("addr_trace", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 65; i++)
      if (chg_log[(wk0 + i) % 1024] !== ((i % 16) == 0)) bad++;
    check("change_positions", 32'(bad), 32'd0);
    if (ba == 8'hF8) begin
      check("wrap_seg1_first", 32'(addr_log[(rd0 + 16) % 1024]), 32'h08);
      check("wrap_seg1_last", 32'(addr_log[(rd0 + 31) % 1024]), 32'h17);
      check("wrap_seg3_first", 32'(addr_log[(rd0 + 48) % 1024]), 32'h28);
      check("wrap_seg3_last", 32'(addr_log[(rd0 + 63) % 1024]), 32'h37);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; base_place = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(8'h00, 8'h05, -1, 1'b0, 1'b0, 1'b0);
    run(8'h40, 8'h12,  1, 1'b0, 1'b0, 1'b0);
    run(8'hF8, 8'h0A, -1, 1'b1, 1'b1, 1'b0);
    run(8'h20, 8'h01, -1, 1'b0, 1'b0, 1'b1);
    run(8'h20, 8'h01, -1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/calcunit_seq.md
Name: calcunit_seq

Overview:
Synchronous sequencer for the eye-distance accumulator unit: clears it, streams 4 window segments of SEG_LEN samples through it via the work/change strobes, closes the accumulation, then reads the 4 segment results out one by one through a valid/ready handshake. Sits between the frame-buffer read port and the result consumer. The memory output feeds the accumulator data inputs directly; this block only sequences them and generates addresses.

Parameters:
SEG_LEN, 16, samples per segment (2..255)
SEG_STRIDE, 16, address offset between segments; matches the accumulator place step
ADDR_W, 8, frame-buffer address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  ADDR_W  address of segment 0, sample 0; latched on accepted start
base_place  in  8  place tag; latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the 4th result is accepted
rd_en  out  1  frame-buffer read; data is valid the next cycle and held until the next rd_en
rd_addr  out  ADDR_W  read address
cu_startsig  out  1  accumulator clear strobe
cu_work  out  1  accumulator sample strobe (unit acts on its rising edge)
cu_change  out  1  segment-boundary flag; stable during the cycle before and the cycle of cu_work
cu_finalstart  out  1  result-load strobe
cu_valid  out  1  result-advance strobe
cu_startplace  out  8  latched base_place
cu_g2sum/cu_gsum/cu_fg/cu_place  in  14/11/14/6  accumulator result bus
res_valid  out  1  result presented
res_ready  in  1  consumer accept
res_g2sum/res_gsum/res_fg/res_place  out  14/11/14/6  registered copy of result bus
res_idx  out  2  segment index of the presented result

Behaviour:
- All outputs are registered. Reset value of every output is 0; the FSM returns to IDLE. A reset mid-run leaves the accumulator stale, and the next start clears it.
- States: IDLE -> CLR (cu_startsig=1) -> CLR_GAP -> {FETCH -> SETUP -> STROBE} x (4*SEG_LEN) -> CL_SETUP -> CL_STROBE -> FIN (cu_finalstart=1) -> SETTLE -> {CAPTURE -> OUT -> ADV} x 4 -> IDLE.
- FETCH: rd_en=1, rd_addr = base_addr + seg*SEG_STRIDE + idx, computed modulo 2^ADDR_W (wraps silently).
- SETUP: cu_change = (idx==0). STROBE: cu_work=1 and cu_change is held. Each sample takes 3 cycles.
- Counters: idx runs 0..SEG_LEN-1, then wraps and seg increments (0..3).
- Close: CL_SETUP/CL_STROBE issue one extra work with change=1 and no fetch. This moves the accumulator past segment 3, and its data is ignored.
- FIN pulses cu_finalstart. SETTLE waits one cycle.
- CAPTURE registers the cu_* result bus into res_*, with res_idx=k.
- OUT holds res_valid=1 and stable res_* until a cycle with res_ready=1. The transfer happens that cycle, and res_valid drops the next cycle.
- ADV: for k<3, cu_valid=1 for one cycle, then return to CAPTURE with k+1. For k=3, no cu_valid; pulse done and go to IDLE.
- At most one of cu_startsig/cu_work/cu_finalstart/cu_valid is high in any cycle, and each is high for exactly one cycle per event.
- Latency from start to first res_valid: 2 + 12*SEG_LEN + 2 + 3 cycles.
- start while busy: ignored, with no effect on the latched values.
- res_ready high before res_valid: ignored.

Decomposition:
- Shared package: FSM state enum, the accumulator result widths (14/11/14/6), and the segment count constant 4.
- One natural sub-module: calcunit_seq_addr (idx/seg counters plus address adder with wrap).

Test Plan:
- Reset then start, SEG_LEN=16, base_addr=0x00, memory returning constant g=1, g2=1, fg=2 -> exactly 1 cu_startsig, 65 cu_work pulses (cu_change on pulses 1, 17, 33, 49, 65) -> results res_idx 0..3 each gsum=16, g2sum=16, fg=32; res_place = base_place + 0x00/0x10/0x20/0x30.
- res_ready held low for 10 cycles at result 1 -> res_valid and res_* stable, no cu_valid pulse until acceptance; done exactly once after the 4th transfer.
- base_addr=0xF8 -> segment 1 reads 0x08..0x17, segment 3 reads 0x28..0x37 (wrap) -> verified via rd_addr trace.
- start pulsed during the sample phase with a different base_addr -> ignored; addresses and done timing unchanged.
- rst asserted mid-segment-2 -> all outputs 0 immediately. A new start re-clears the accumulator, and the results match a clean run.
- Protocol checker throughout: one-hot strobes, cu_change stable across each work setup/strobe pair, first res_valid at cycle 2+192+2+3 after start.
